// File: rtl/rf_scoreboard_pkg.sv
// Shared processor constants for the register file and its write scoreboard.
// Holds the architectural register count, the in-flight counter width and the
// register-index width, so rf and rf_scoreboard always agree on sizing.
package rf_scoreboard_pkg;

  // Number of architectural registers (matches the 8-entry register file).
  localparam int NREG  = 8;
  // Width of each per-register in-flight write counter (max count 3).
  localparam int CNT_W = 2;
  // Register-index width (rf read1regsel/read2regsel/writeregsel encoding).
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] reg_idx_t;

  // True when a register index selects register number n.
  function automatic logic idx_is(input reg_idx_t idx, input int n);
    return (int'(idx) == n);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Purpose: CNT_W-bit saturating up/down counter for one register's in-flight writes.
// Latency: count updates on the edge after inc/dec/clr; nz/underflow follow the count.
// Backpressure: none here; the caller must not increment at max (the top stalls instead).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   inc_i           an accepted issue writes this register
//   dec_i           writeback retires a write to this register
//   clr_i           flush; clears the count and suppresses underflow
//   cnt_o           current count
//   nz_o            count is nonzero
//   underflow_o     dec_i presented with count already zero (and no flush)
module sb_counter
  import rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = rf_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Simultaneous inc and dec cancel, including at zero: the count stays put
  // while the underflow is still reported for the retired-but-unknown write.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q != CNT_ZERO) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign nz_o        = (cnt_q != CNT_ZERO);
  // A flush discards everything in flight, so a stray writeback in that
  // cycle is not treated as a protocol error.
  assign underflow_o = dec_i && !clr_i && (cnt_q == CNT_ZERO);

endmodule

// File: rtl/rf_scoreboard.sv
// Purpose: register-file write scoreboard; tracks in-flight writes and stalls RAW/overflow issues.
// Latency: stall is combinational from current counts; pending/err update on the next edge.
// Backpressure: stall holds decode; flush is not folded into stall (decode qualifies it).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   issue_valid/issue_wr          instruction presented / it writes issue_dst
//   issue_dst                     destination register index
//   issue_src1/src1_used          first source index / it is read
//   issue_src2/src2_used          second source index / it is read
//   wb_valid/wb_reg               writeback retires a write to wb_reg
//   flush                         discard all in-flight writes
//   stall                         decode must hold the presented instruction
//   pending                       bit i set while register i has writes in flight
//   err                           sticky writeback-underflow flag, cleared only by rst
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int NREG  = rf_scoreboard_pkg::NREG,
  parameter int CNT_W = rf_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic [IDX_W-1:0] issue_dst,
  input  logic [IDX_W-1:0] issue_src1,
  input  logic             src1_used,
  input  logic [IDX_W-1:0] issue_src2,
  input  logic             src2_used,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_reg,
  input  logic             flush,
  output logic             stall,
  output logic [NREG-1:0]  pending,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  nz;
  logic [NREG-1:0]  uf;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;

  logic             src1_hit;
  logic             src2_hit;
  logic             dst_full;
  logic             issue_acc;
  logic             err_q;
  logic             err_d;

  // ------------------------------------------------------------------
  // Stall: RAW hazard on either used source, or destination counter full.
  // Uses the current counts only; a same-cycle writeback does not bypass.
  // ------------------------------------------------------------------
  always_comb begin
    src1_hit = 1'b0;
    src2_hit = 1'b0;
    dst_full = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_is(issue_src1, i) && nz[i]) begin
        src1_hit = 1'b1;
      end
      if (idx_is(issue_src2, i) && nz[i]) begin
        src2_hit = 1'b1;
      end
      if (idx_is(issue_dst, i) && (cnt[i] == CNT_MAX)) begin
        dst_full = 1'b1;
      end
    end
  end

  assign stall = issue_valid && ((src1_used && src1_hit) ||
                                 (src2_used && src2_hit) ||
                                 (issue_wr  && dst_full));

  assign issue_acc = issue_valid && !stall;

  // ------------------------------------------------------------------
  // Per-register increment/decrement strobes.
  // ------------------------------------------------------------------
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = issue_acc && issue_wr && idx_is(issue_dst, i);
      dec[i] = wb_valid && idx_is(wb_reg, i);
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc[g]),
      .dec_i      (dec[g]),
      .clr_i      (flush),
      .cnt_o      (cnt[g]),
      .nz_o       (nz[g]),
      .underflow_o(uf[g])
    );
  end

  // ------------------------------------------------------------------
  // Sticky error: set by any underflow, survives flush, cleared by rst.
  // ------------------------------------------------------------------
  assign err_d = err_q || (|uf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // nz is a pure function of the counter flops, so pending only moves at
  // an edge (or immediately on rst).
  assign pending = nz;
  assign err     = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic       issue_wr;
  logic [2:0] issue_dst;
  logic [2:0] issue_src1;
  logic       src1_used;
  logic [2:0] issue_src2;
  logic       src2_used;
  logic       wb_valid;
  logic [2:0] wb_reg;
  logic       flush;
  logic       stall;
  logic [7:0] pending;
  logic       err;

  rf_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_wr   (issue_wr),
    .issue_dst  (issue_dst),
    .issue_src1 (issue_src1),
    .src1_used  (src1_used),
    .issue_src2 (issue_src2),
    .src2_used  (src2_used),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .flush      (flush),
    .stall      (stall),
    .pending    (pending),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain per-register in-flight counts and an error bit.
  int m_cnt [8];
  bit m_err;
  bit st_seen;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit exp_stall();
    return issue_valid && ((src1_used && m_cnt[issue_src1] != 0) ||
                           (src2_used && m_cnt[issue_src2] != 0) ||
                           (issue_wr  && m_cnt[issue_dst] == 3));
  endfunction

  function automatic logic [7:0] exp_pending();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_err = 0;
  endtask

  task automatic model_edge(input bit st);
    int old [8];
    bit wr_acc;
    for (int i = 0; i < 8; i++) old[i] = m_cnt[i];
    if (flush) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      wr_acc = issue_valid && !st && issue_wr;
      if (wb_valid && old[wb_reg] == 0) m_err = 1;
      if (!(wr_acc && wb_valid && issue_dst == wb_reg)) begin
        if (wr_acc) m_cnt[issue_dst] = old[issue_dst] + 1;
        if (wb_valid && old[wb_reg] != 0) m_cnt[wb_reg] = old[wb_reg] - 1;
      end
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_dst = 0;
    issue_src1 = 0; src1_used = 0; issue_src2 = 0; src2_used = 0;
    wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  task automatic drive(input bit iv, input bit wr, input int dst,
                       input int s1, input bit s1u, input int s2, input bit s2u,
                       input bit wbv, input int wbr, input bit fl);
    issue_valid = iv; issue_wr = wr; issue_dst = 3'(dst);
    issue_src1 = 3'(s1); src1_used = s1u; issue_src2 = 3'(s2); src2_used = s2u;
    wb_valid = wbv; wb_reg = 3'(wbr); flush = fl;
  endtask

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic cycle();
    bit es;
    es = exp_stall();
    #1;
    check("stall", {7'b0, stall}, {7'b0, es});
    st_seen = stall;
    @(posedge clk);
    model_edge(es);
    @(negedge clk);
    check("pending", pending, exp_pending());
    check("err", {7'b0, err}, {7'b0, m_err});
    idle();
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    idle();
    #2 rst = 1;
    #1;
    check("rst_async_pending", pending, 8'h00);
    check("rst_async_err", {7'b0, err}, 8'h00);
    check("rst_stall", {7'b0, stall}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    check("reset_pending", pending, 8'h00);
    check("reset_err", {7'b0, err}, 8'h00);

    // RAW hazard on r3 held until writeback, no same-cycle bypass.
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("raw_pend08", pending, 8'h08);
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); cycle();
    check("raw_stall", {7'b0, st_seen}, 8'h01);
    drive(1, 0, 0, 3, 1, 0, 0, 1, 3, 0); cycle();
    check("raw_nobypass", {7'b0, st_seen}, 8'h01);
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); cycle();
    check("raw_release", {7'b0, st_seen}, 8'h00);

    // Saturation at 3 on r5.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
    end
    check("sat_model3", 8'(m_cnt[5]), 8'd3);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("sat_stall", {7'b0, st_seen}, 8'h01);
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); cycle();
    check("sat_stall_wb", {7'b0, st_seen}, 8'h01);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("sat_accept", {7'b0, st_seen}, 8'h00);
    check("sat_model3b", 8'(m_cnt[5]), 8'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();

    // Same-cycle write and writeback on r2 cancel.
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 2, 0, 0, 0, 0, 1, 2, 0); cycle();
    check("cancel_pend", pending, 8'h04);
    check("cancel_model1", 8'(m_cnt[2]), 8'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0); cycle();
    check("cancel_drain", pending, 8'h00);

    // Underflow on r6: sticky through flush, cleared by rst.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); cycle();
    check("uf_err", {7'b0, err}, 8'h01);
    check("uf_pend", pending, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    check("uf_sticky", {7'b0, err}, 8'h01);
    mid_reset();
    check("uf_cleared", {7'b0, err}, 8'h00);

    // Flush beats a same-cycle write.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("fl_pend92", pending, 8'h92);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    check("fl_nostall", {7'b0, st_seen}, 8'h00);
    check("fl_pend00", pending, 8'h00);
    check("fl_err0", {7'b0, err}, 8'h00);

    // Async reset with every register pending and err set.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); cycle();
    for (int r = 0; r < 8; r++) begin
      drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0); cycle();
    end
    check("full_pendFF", pending, 8'hFF);
    check("full_err1", {7'b0, err}, 8'h01);
    mid_reset();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int wbr;
      wbr = $urandom_range(0, 7);
      for (int t = 0; t < 8 && m_cnt[wbr] == 0; t++) wbr = $urandom_range(0, 7);
      if ($urandom_range(0, 99) < 5) wbr = $urandom_range(0, 7);
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 99) < 40,
            $urandom_range(0, 7), $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 55, wbr, $urandom_range(0, 99) < 3);
      cycle();
      if (c % 500 == 499) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
